vga_timing_gen: RTL and testbench

//  Source end of vga_if: generates the hcount/vcount raster, sync and blanking for the
//  1024x768@60 display and drives vga_if.out into the first overlay stage (background,

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing source into the overlay chain.
interface vga_timing_gen_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster generator for 1024x768@60 with line/frame strobes and a frame counter.
// Sync, blank and strobes are decoded from the next-count values so every field lines up.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   out,
  output logic               frame_start,
  output logic               line_start,
  output logic [15:0]        frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_param_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK_FROM = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_FROM  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_TO    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLANK_FROM = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_FROM  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_TO    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 11'd1;
    end

    hblnk_d = (hcount_d >= H_BLANK_FROM);
    hsync_d = (hcount_d >= H_SYNC_FROM) && (hcount_d <= H_SYNC_TO);
    vblnk_d = (vcount_d >= V_BLANK_FROM);
    vsync_d = (vcount_d >= V_SYNC_FROM) && (vcount_d <= V_SYNC_TO);

    // The count leaving reset is never 0, so no strobe fires on release.
    line_start_d  = (hcount_d == '0);
    frame_start_d = line_start_d && (vcount_d == '0);
    frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign out.hcount  = hcount_q;
  assign out.vcount  = vcount_q;
  assign out.hsync   = hsync_q;
  assign out.hblnk   = hblnk_q;
  assign out.vsync   = vsync_q;
  assign out.vblnk   = vblnk_q;
  assign out.rgb     = 12'h000;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunken one for frame-level behaviour.
module tb_vga_timing_gen;
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int S_PERIOD = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  typedef struct {
    int hcount;
    int vcount;
    bit hsync;
    bit hblnk;
    bit vsync;
    bit vblnk;
    bit lineStart;
    bit frameStart;
    int frameCnt;
  } rasterT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if fullIf ();
  vga_timing_gen_if smallIf ();
  logic        fullFrameStart, fullLineStart, smallFrameStart, smallLineStart;
  logic [15:0] fullFrameCnt, smallFrameCnt;

  vga_timing_gen uFull (
    .clk(clk), .rst(rst), .out(fullIf.master),
    .frame_start(fullFrameStart), .line_start(fullLineStart), .frame_cnt(fullFrameCnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) uSmall (
    .clk(clk), .rst(rst), .out(smallIf.master),
    .frame_start(smallFrameStart), .line_start(smallLineStart), .frame_cnt(smallFrameCnt)
  );

  logic [55:0] fullVec, smallVec;
  assign fullVec  = {fullIf.hcount, fullIf.vcount, fullIf.hsync, fullIf.hblnk, fullIf.vsync,
                     fullIf.vblnk, fullIf.rgb, fullLineStart, fullFrameStart, fullFrameCnt};
  assign smallVec = {smallIf.hcount, smallIf.vcount, smallIf.hsync, smallIf.hblnk, smallIf.vsync,
                     smallIf.vblnk, smallIf.rgb, smallLineStart, smallFrameStart, smallFrameCnt};

  int     testsRun = 0;
  int     testsFailed = 0;
  longint k = 0;
  longint smallOff = 0;
  bit     scoreEn = 1'b0;
  rasterT sbFull, sbSmall;

  // Raster position is simply the number of clocks since reset released, folded by the frame length.
  function automatic rasterT modelAt(input bit isSmall, input longint kk, input longint off);
    rasterT r;
    longint hAct = isSmall ? S_HA : 1024;
    longint hFp  = isSmall ? S_HF : 24;
    longint hSy  = isSmall ? S_HS : 136;
    longint hBp  = isSmall ? S_HB : 160;
    longint vAct = isSmall ? S_VA : 768;
    longint vFp  = isSmall ? S_VF : 3;
    longint vSy  = isSmall ? S_VS : 6;
    longint vBp  = isSmall ? S_VB : 29;
    longint ht   = hAct + hFp + hSy + hBp;
    longint vt   = vAct + vFp + vSy + vBp;
    longint per  = ht * vt;
    longint p    = kk % per;
    longint h    = p % ht;
    longint v    = p / ht;
    r.hcount     = int'(h);
    r.vcount     = int'(v);
    r.hblnk      = (h >= hAct);
    r.hsync      = (h >= hAct + hFp) && (h < hAct + hFp + hSy);
    r.vblnk      = (v >= vAct);
    r.vsync      = (v >= vAct + vFp) && (v < vAct + vFp + vSy);
    r.lineStart  = (kk > 0) && (h == 0);
    r.frameStart = (kk > 0) && (p == 0);
    r.frameCnt   = (kk == 0) ? 0 : int'((kk / per + off) % 65536);
    return r;
  endfunction

  function automatic logic [55:0] packExp(input rasterT r);
    return {11'(r.hcount), 11'(r.vcount), r.hsync, r.hblnk, r.vsync, r.vblnk, 12'h000,
            r.lineStart, r.frameStart, 16'(r.frameCnt)};
  endfunction

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Every-cycle scoreboard, sampled well after the edge.
  always @(posedge clk) begin
    #2;
    if (scoreEn) begin
      sbFull  = modelAt(1'b0, k, 0);
      sbSmall = modelAt(1'b1, k, smallOff);
      testsRun += 2;
      if (fullVec !== packExp(sbFull)) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard_full k=%0d got %h expected %h", k, fullVec, packExp(sbFull));
      end
      if (smallVec !== packExp(sbSmall)) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard_small k=%0d got %h expected %h", k, smallVec, packExp(sbSmall));
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    smallOff = 0;
    repeat (5) begin
      @(negedge clk);
      testsRun++;
      if ((fullVec !== 56'd0) || (smallVec !== 56'd0)) begin
        testsFailed++;
        $display("[TB] FAIL reset_values got full=%h small=%h expected 0", fullVec, smallVec);
      end
    end
    scoreEn = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if ((fullIf.hcount !== 11'd1) || (fullIf.vcount !== 11'd0) || (fullIf.hsync !== 1'b0) ||
        (fullIf.hblnk !== 1'b0) || (fullIf.vsync !== 1'b0) || (fullIf.vblnk !== 1'b0) ||
        (fullIf.rgb !== 12'h000)) begin
      testsFailed++;
      $display("[TB] FAIL first_after_release got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b rgb=%h expected h=1 v=0 rest 0",
               fullIf.hcount, fullIf.vcount, fullIf.hsync, fullIf.hblnk, fullIf.vsync, fullIf.vblnk, fullIf.rgb);
    end
  endtask

  task automatic test_line_timing();
    int  firstBlank = -1, syncFirst = -1, syncLast = -1, syncCount = 0;
    bit  found = 1'b0;
    for (int i = 0; i < 2 * 1344; i++) begin
      @(negedge clk);
      if (fullIf.hblnk && (firstBlank < 0)) firstBlank = int'(fullIf.hcount);
      if (fullIf.hsync) begin
        syncCount++;
        if (syncFirst < 0) syncFirst = int'(fullIf.hcount);
        syncLast = int'(fullIf.hcount);
      end
      if (fullIf.hcount == 11'd1343) begin
        found = 1'b1;
        break;
      end
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL line_end_timeout got no hcount=1343 expected one within 2688 cycles");
    end
    testsRun++;
    if ((firstBlank != 1024) || (syncFirst != 1048) || (syncLast != 1183) || (syncCount != 136)) begin
      testsFailed++;
      $display("[TB] FAIL hsync_hblnk_window got blank@%0d sync %0d..%0d n=%0d expected blank@1024 sync 1048..1183 n=136",
               firstBlank, syncFirst, syncLast, syncCount);
    end
    @(negedge clk);
    testsRun++;
    if ((fullIf.hcount !== 11'd0) || (fullLineStart !== 1'b1) || (fullIf.vcount !== 11'd1)) begin
      testsFailed++;
      $display("[TB] FAIL line_wrap got h=%0d ls=%b v=%0d expected h=0 ls=1 v=1",
               fullIf.hcount, fullLineStart, fullIf.vcount);
    end
  endtask

  task automatic test_frame_timing();
    int vbFirst = -1, vbLast = -1, vsFirst = -1, vsLast = -1, period = -1;
    bit found = 1'b0;
    for (int i = 0; i < 2 * S_PERIOD; i++) begin
      @(negedge clk);
      if (smallFrameStart) begin
        found = 1'b1;
        break;
      end
    end
    for (int i = 1; found && (i <= 2 * S_PERIOD); i++) begin
      @(negedge clk);
      if (smallIf.vblnk) begin
        if (vbFirst < 0) vbFirst = int'(smallIf.vcount);
        vbLast = int'(smallIf.vcount);
      end
      if (smallIf.vsync) begin
        if (vsFirst < 0) vsFirst = int'(smallIf.vcount);
        vsLast = int'(smallIf.vcount);
      end
      if (smallFrameStart) begin
        period = i;
        break;
      end
    end
    testsRun++;
    if (period != S_PERIOD) begin
      testsFailed++;
      $display("[TB] FAIL frame_period got %0d expected %0d", period, S_PERIOD);
    end
    testsRun++;
    if ((vbFirst != 6) || (vbLast != 11) || (vsFirst != 7) || (vsLast != 8)) begin
      testsFailed++;
      $display("[TB] FAIL vsync_vblnk_window got vblnk %0d..%0d vsync %0d..%0d expected vblnk 6..11 vsync 7..8",
               vbFirst, vbLast, vsFirst, vsLast);
    end
  endtask

  task automatic test_counter();
    int seen = 0;
    @(negedge clk);
    rst = 1'b1;
    smallOff = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4 * S_PERIOD; i++) begin
      @(negedge clk);
      if (smallFrameStart) seen++;
      if (seen == 3) break;
    end
    testsRun++;
    if ((seen != 3) || (smallFrameCnt !== 16'd3)) begin
      testsFailed++;
      $display("[TB] FAIL frame_cnt_three got frames=%0d cnt=%0d expected frames=3 cnt=3", seen, smallFrameCnt);
    end
    @(negedge clk);
    smallOff = 65535 - (k / S_PERIOD);
    force uSmall.frame_cnt_q = 16'hFFFF;
    #1;
    release uSmall.frame_cnt_q;
    seen = 0;
    for (int i = 0; i < 2 * S_PERIOD; i++) begin
      @(negedge clk);
      if (smallFrameStart) begin
        seen = 1;
        break;
      end
    end
    testsRun++;
    if ((seen != 1) || (smallFrameCnt !== 16'd0)) begin
      testsFailed++;
      $display("[TB] FAIL frame_cnt_wrap got seen=%0d cnt=%0d expected seen=1 cnt=0", seen, smallFrameCnt);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    int steps = -1;
    for (int i = 0; i < 2 * S_PERIOD; i++) begin
      @(negedge clk);
      if ((smallIf.hcount == 11'd5) && (smallIf.vcount == 11'd4)) begin
        found = 1'b1;
        break;
      end
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_position got no (5,4) expected it within %0d cycles", 2 * S_PERIOD);
    end
    rst = 1'b1;
    smallOff = 0;
    @(negedge clk);
    testsRun++;
    if ((smallVec !== 56'd0) || (fullVec !== 56'd0)) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_zero got full=%h small=%h expected 0", fullVec, smallVec);
    end
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if ((smallIf.hcount !== 11'd1) || (smallIf.vcount !== 11'd0) || (smallFrameCnt !== 16'd0)) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_release got h=%0d v=%0d cnt=%0d expected h=1 v=0 cnt=0",
               smallIf.hcount, smallIf.vcount, smallFrameCnt);
    end
    for (int i = 1; i <= 2 * S_PERIOD; i++) begin
      @(negedge clk);
      if (smallFrameStart) begin
        steps = i;
        break;
      end
    end
    testsRun++;
    if (steps != S_PERIOD - 1) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_next_frame got %0d expected %0d", steps, S_PERIOD - 1);
    end
  endtask

  task automatic test_random_resets();
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(1, 400)) @(negedge clk);
      rst = 1'b1;
      smallOff = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      testsRun++;
      if ((smallVec !== 56'd0) || (fullVec !== 56'd0)) begin
        testsFailed++;
        $display("[TB] FAIL random_reset_zero iter=%0d got full=%h small=%h expected 0", n, fullVec, smallVec);
      end
      rst = 1'b0;
      @(negedge clk);
      testsRun++;
      if ((fullIf.hcount !== 11'd1) || (smallIf.hcount !== 11'd1) || (smallIf.vcount !== 11'd0)) begin
        testsFailed++;
        $display("[TB] FAIL random_reset_release iter=%0d got full.h=%0d small.h=%0d small.v=%0d expected 1 1 0",
                 n, fullIf.hcount, smallIf.hcount, smallIf.vcount);
      end
    end
    repeat (S_PERIOD + 20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_counter();
    test_mid_reset();
    test_random_resets();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
